data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit storage words.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted between request accept and response.
REQ-003 clk  input  1  single clock; all logic SHALL sample on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_funct3  input  3  RV32I size/sign code: LB/LH/LW/LBU/LHU, SB/SH/SW.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  response present.
REQ-012 resp_ready  input  1  initiator accepts response.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 resp_err  output  1  request faulted; no store was performed.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; only one request SHALL be outstanding at a time.
REQ-016 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid && req_ready, and addr, we, funct3 and wdata SHALL be latched.
REQ-017 On accept, the FSM SHALL go to WAIT with counter = WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES==0.
REQ-018 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL go to RESP on the cycle after the counter reads 0.
REQ-019 Total latency SHALL be exactly WAIT_CYCLES+1 cycles from the accept edge to the first cycle of resp_valid=1.
REQ-020 A store SHALL write memory exactly once, on the edge entering RESP, using byte lanes selected by funct3 and addr[1:0]; unselected bytes SHALL be unchanged.
REQ-021 A load SHALL extract the addressed byte or half from the word; LB and LH SHALL sign-extend, LBU and LHU SHALL zero-extend, and LW SHALL pass the word through.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL stay stable until resp_ready=1; on that handshake the FSM SHALL return to IDLE.
REQ-023 Maximum throughput SHALL be one request per WAIT_CYCLES+2 cycles, because accept is possible in the cycle after the response handshake.
REQ-024 A word index (addr[31:2]) >= DEPTH_WORDS SHALL set resp_err=1 and resp_rdata=0, and SHALL suppress the write.
REQ-025 Illegal funct3 values (load 3/6/7; store >2) SHALL set resp_err=1 and suppress the write.
REQ-026 A store followed immediately by a load to the same address SHALL return the newly stored data.

Reset
REQ-027 While rst=1: state=IDLE, counter=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-028 req_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset in WAIT SHALL abort the request, and the pending store SHALL NOT be performed.
REQ-030 Reset in RESP SHALL drop the response; the store has already been committed.
REQ-031 Memory contents SHALL NOT be reset.

Configuration
REQ-032 Macro DMEM_MISALIGN_TRAP_EN defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL give resp_err=1, resp_rdata=0 and no write.
REQ-033 DMEM_MISALIGN_TRAP_EN undefined: misaligned offset bits SHALL be forced to 0 (halfword uses addr[1] only; word ignores addr[1:0]), and resp_err SHALL arise only from REQ-024/REQ-025.

Structure
REQ-034 The shared package dmem_pkg SHALL hold the state enum, the funct3 constants (LB..LHU, SB..SW) and the default DEPTH_WORDS/WAIT_CYCLES values.
REQ-035 Combinational lane insert/extract and sign extension SHALL live in the sub-module dmem_lane_align; data_mem_responder SHALL hold the FSM, the counter, the request latches and the storage array.

Verification
REQ-036 Reset, then SW 0xDEADBEEF to 0x10 followed by LW 0x10 (WAIT_CYCLES=2) -> resp_valid 3 cycles after each accept, rdata=0xDEADBEEF, err=0.
REQ-037 After REQ-036, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; SB 0x55 to 0x11 then LW 0x10 -> 0xDEAD55EF.
REQ-038 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable and req_ready=0 throughout; accept possible in the cycle after the handshake.
REQ-039 Addr 0x1000 with DEPTH_WORDS=1024 -> err=1 and memory unchanged; SW 0x12 -> err=1 with the macro defined, and a write to 0x10 without it.
REQ-040 Assert rst during WAIT of SW 0xA5A5A5A5 to 0x20 -> LW 0x20 after reset returns the old value; req_ready=1 in the first post-reset cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// RV32I load/store funct3 codes and default geometry.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH_WORDS = 1024;
  localparam int unsigned DMEM_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } dmem_state_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane merge for stores and lane extract / sign extension for loads.
// DMEM_MISALIGN_TRAP_EN: misaligned half/word flags an error instead of masking offset bits.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o,
  output logic        fmt_err_o
);

  logic [1:0]  size;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    size      = funct3_i[1:0];
    sext      = !funct3_i[2];
    off       = off_i;
    fmt_err_o = we_i ? !(funct3_i inside {F3_SB, F3_SH, F3_SW})
                     : !(funct3_i inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((size == 2'd1 && off_i[0]) || (size == 2'd2 && off_i != 2'b00)) begin
      fmt_err_o = 1'b1;
    end
`else
    if (size == 2'd1) begin
      off = {off_i[1], 1'b0};
    end else if (size == 2'd2) begin
      off = 2'b00;
    end
`endif

    case (size)
      2'd0: begin
        be   = 4'b0001 << off;
        wrep = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata_i[15:0]}};
      end
      default: begin
        be   = '1;
        wrep = wdata_i;
      end
    endcase

    wword_o = word_i;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) wword_o[8*b +: 8] = wrep[8*b +: 8];
    end

    shifted = word_i >> {off, 3'b000};
    case (size)
      2'd0:    rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
      2'd1:    rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: rdata_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding RV32I data memory with fixed wait states and a held response.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
  localparam logic NO_WAIT = (WAIT_CYCLES == 0);

  dmem_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [2:0]    f3_q;
  logic          we_q, err_q;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept, enter_resp, in_range, fmt_err, err;
  logic          cur_we;
  logic [31:0]   cur_addr, cur_wdata, rd_word, wword, lane_rdata;
  logic [2:0]    cur_f3;
  logic [IW-1:0] idx;

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_RESP) && !rst;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && req_ready;

  // With zero wait states RESP is entered on the accept edge, before the
  // latches update, so the live request feeds the datapath while in IDLE.
  assign cur_we    = (state_q == ST_IDLE) ? req_we     : we_q;
  assign cur_addr  = (state_q == ST_IDLE) ? req_addr   : addr_q;
  assign cur_f3    = (state_q == ST_IDLE) ? req_funct3 : f3_q;
  assign cur_wdata = (state_q == ST_IDLE) ? req_wdata  : wdata_q;

  assign in_range = {2'b00, cur_addr[31:2]} < 32'(DEPTH_WORDS);
  assign idx      = cur_addr[IW+1:2];
  assign rd_word  = in_range ? mem_q[idx] : '0;
  assign err      = !in_range || fmt_err;

  dmem_lane_align u_lane (
    .we_i      (cur_we),
    .funct3_i  (cur_f3),
    .off_i     (cur_addr[1:0]),
    .wdata_i   (cur_wdata),
    .word_i    (rd_word),
    .wword_o   (wword),
    .rdata_o   (lane_rdata),
    .fmt_err_o (fmt_err)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        rdata_q <= (cur_we || err) ? '0 : lane_rdata;
        err_q   <= err;
      end else if (state_q == ST_RESP && resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      we_q    <= req_we;
      f3_q    <= req_funct3;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_we && !err) begin
      mem_q[idx] <= wword;
    end
  end

endmodule
